// File: rtl/acq_pkg.sv
// acq_pkg: state encoding and Lite status word layout shared by the acquisition sequencer.
`default_nettype none

package acq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFILL = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  localparam int STAT_W            = 7;
  localparam int STAT_STATE_LSB    = 0;
  localparam int STAT_ADC_RUN_BIT  = 3;
  localparam int STAT_DAC_RUN_BIT  = 4;
  localparam int STAT_UNDERRUN_BIT = 5;
  localparam int STAT_OVERRUN_BIT  = 6;

  function automatic logic [STAT_W-1:0] pack_status(
    input logic [2:0] st,
    input logic       adc_run,
    input logic       dac_run,
    input logic       underrun,
    input logic       overrun
  );
    logic [STAT_W-1:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 3]  = st;
    w[STAT_ADC_RUN_BIT]     = adc_run;
    w[STAT_DAC_RUN_BIT]     = dac_run;
    w[STAT_UNDERRUN_BIT]    = underrun;
    w[STAT_OVERRUN_BIT]     = overrun;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acq_sequencer.sv
//==============================================================================
// acq_sequencer: aligns ADC capture and DAC playback to a common frame,
// counts frames and latches underrun/overrun faults.
// Revision: 1.0
//==============================================================================
`default_nettype none

module acq_sequencer
  import acq_pkg::*;
#(
  parameter int CNT_W   = 11,
  parameter int PREFILL = 256,
  parameter int FRAME_W = 32
) (
  input  logic               capture_clk,
  input  logic               rst,
  input  logic               dac_open,
  input  logic               adc_open,
  input  logic [CNT_W-1:0]   dac_fill,
  input  logic               dac_empty,
  input  logic               capture_full,
  input  logic               frame_tick,
  input  logic               sw_stop,
  input  logic               fault_clr,
  output logic               adc_run,
  output logic               dac_run,
  output logic [FRAME_W-1:0] frame_count,
  output logic [2:0]         state,
  output logic               underrun,
  output logic               overrun
);

  localparam logic [CNT_W-1:0] PREFILL_LVL = CNT_W'(PREFILL);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic               r_adc_run, r_dac_run, r_underrun, r_overrun;
  logic               w_adc_run, w_dac_run, w_underrun, w_overrun;
  logic [FRAME_W-1:0] r_frame_count, w_frame_count;
  logic               w_close, w_underrun_det, w_overrun_det;

  // Fault detection only applies while running with the ADC channel still open;
  // a dac_empty between ticks may just be a read still in flight.
  assign w_close        = !dac_open || !adc_open || sw_stop;
  assign w_underrun_det = (r_state == ST_RUN) && adc_open && dac_empty && frame_tick;
  assign w_overrun_det  = (r_state == ST_RUN) && adc_open && capture_full;

  always_ff @(posedge capture_clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_adc_run     <= 1'b0;
      r_dac_run     <= 1'b0;
      r_frame_count <= '0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_adc_run     <= w_adc_run;
      r_dac_run     <= w_dac_run;
      r_frame_count <= w_frame_count;
      r_underrun    <= w_underrun;
      r_overrun     <= w_overrun;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dac_open && adc_open && !sw_stop) w_next_state = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (w_close)                    w_next_state = ST_IDLE;
        else if (dac_fill >= PREFILL_LVL) w_next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_close)         w_next_state = ST_IDLE;
        else if (frame_tick) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!adc_open)                           w_next_state = ST_IDLE;
        else if (w_underrun_det || w_overrun_det) w_next_state = ST_FAULT;
        else if (sw_stop || !dac_open)           w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!adc_open || frame_tick) w_next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_adc_run     = (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
    w_dac_run     = (w_next_state == ST_RUN);
    w_frame_count = r_frame_count;
    if (r_state == ST_ARMED && w_next_state == ST_RUN)
      w_frame_count = '0;
    else if (r_state == ST_RUN && w_next_state == ST_RUN && frame_tick)
      w_frame_count = r_frame_count + 1'b1;
    // A new fault in the same cycle as fault_clr stays latched.
    w_underrun = (r_underrun && !fault_clr) || w_underrun_det;
    w_overrun  = (r_overrun  && !fault_clr) || w_overrun_det;
  end

  assign adc_run     = r_adc_run;
  assign dac_run     = r_dac_run;
  assign frame_count = r_frame_count;
  assign state       = r_state;
  assign underrun    = r_underrun;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed bench for acq_sequencer (32-bit and 4-bit frame counters side by side).
`default_nettype none

module tb_acq_sequencer;

  logic        capture_clk = 1'b0;
  logic        rst = 1'b1;
  logic        dac_open = 1'b0, adc_open = 1'b0;
  logic [10:0] dac_fill = '0;
  logic        dac_empty = 1'b0, capture_full = 1'b0, frame_tick = 1'b0;
  logic        sw_stop = 1'b0, fault_clr = 1'b0;

  logic        adc_run, dac_run, underrun, overrun;
  logic [31:0] frame_count;
  logic [2:0]  state;
  logic        adc_run4, dac_run4, underrun4, overrun4;
  logic [3:0]  frame_count4;
  logic [2:0]  state4;

  int passes = 0;
  int total  = 0;

  always #5 capture_clk = ~capture_clk;

  acq_sequencer #(.CNT_W(11), .PREFILL(256), .FRAME_W(32)) dut (
    .capture_clk(capture_clk), .rst(rst), .dac_open(dac_open), .adc_open(adc_open),
    .dac_fill(dac_fill), .dac_empty(dac_empty), .capture_full(capture_full),
    .frame_tick(frame_tick), .sw_stop(sw_stop), .fault_clr(fault_clr),
    .adc_run(adc_run), .dac_run(dac_run), .frame_count(frame_count), .state(state),
    .underrun(underrun), .overrun(overrun)
  );

  acq_sequencer #(.CNT_W(11), .PREFILL(256), .FRAME_W(4)) dut4 (
    .capture_clk(capture_clk), .rst(rst), .dac_open(dac_open), .adc_open(adc_open),
    .dac_fill(dac_fill), .dac_empty(dac_empty), .capture_full(capture_full),
    .frame_tick(frame_tick), .sw_stop(sw_stop), .fault_clr(fault_clr),
    .adc_run(adc_run4), .dac_run(dac_run4), .frame_count(frame_count4), .state(state4),
    .underrun(underrun4), .overrun(overrun4)
  );

  task automatic step();
    @(posedge capture_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic ar, input logic dr,
                         input logic [31:0] fc, input logic ur, input logic ovr);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".adc_run"}, {31'd0, adc_run}, {31'd0, ar});
    chk({tag, ".dac_run"}, {31'd0, dac_run}, {31'd0, dr});
    chk({tag, ".frame_count"}, frame_count, fc);
    chk({tag, ".underrun"}, {31'd0, underrun}, {31'd0, ur});
    chk({tag, ".overrun"}, {31'd0, overrun}, {31'd0, ovr});
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // From IDLE with both channels open and fill above threshold: PREFILL, ARMED, then RUN.
  task automatic arm_and_start(input string tag);
    step();
    chk({tag, ".prefill"}, {29'd0, state}, 32'd1);
    step();
    chk({tag, ".armed"}, {29'd0, state}, 32'd2);
    tick();
    chk_all({tag, ".run"}, 3'd3, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    step(); step();
    rst = 1'b0;
    step();
    chk_all("reset", 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Prefill ramp 0..300
    dac_open = 1'b1; adc_open = 1'b1;
    step();
    chk("open.prefill", {29'd0, state}, 32'd1);
    for (int f = 0; f <= 300; f++) begin
      dac_fill = 11'(f);
      step();
      if (f == 255 || f == 256 || f == 300)
        chk($sformatf("ramp.fill%0d", f), {29'd0, state}, (f >= 256) ? 32'd2 : 32'd1);
    end
    chk("armed.adc_run", {31'd0, adc_run}, 32'd0);
    tick();
    chk_all("start", 3'd3, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
    chk("start.fc4", {28'd0, frame_count4}, 32'd0);

    // Counting and 4-bit wrap
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk($sformatf("wrap.fc4.%0d", i), {28'd0, frame_count4}, 32'(i % 16));
      chk($sformatf("cnt.fc32.%0d", i), frame_count, 32'(i));
    end
    chk("wrap.run", {30'd0, adc_run4, dac_run4}, 32'd3);

    // Drain
    step();
    sw_stop = 1'b1;
    step();
    chk_all("drain.enter", 3'd4, 1'b1, 1'b0, 32'd17, 1'b0, 1'b0);
    step(); step();
    chk("drain.hold.adc_run", {31'd0, adc_run}, 32'd1);
    tick();
    chk_all("drain.exit", 3'd0, 1'b0, 1'b0, 32'd17, 1'b0, 1'b0);
    sw_stop = 1'b0;

    // Underrun: ignored between ticks, faults on a tick
    arm_and_start("ur");
    tick();
    chk("ur.cnt1", frame_count, 32'd1);
    dac_empty = 1'b1;
    step();
    chk_all("ur.notick", 3'd3, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0);
    tick();
    chk_all("ur.fault", 3'd5, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0);
    dac_empty = 1'b0;
    tick(); tick();
    chk_all("ur.frozen", 3'd5, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk_all("ur.clear", 3'd0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);

    // Overrun alone on a non-tick cycle
    arm_and_start("ov");
    capture_full = 1'b1;
    step();
    capture_full = 1'b0;
    chk_all("ov.fault", 3'd5, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk_all("ov.clear", 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Simultaneous underrun and overrun on a tick
    arm_and_start("both");
    tick();
    capture_full = 1'b1; dac_empty = 1'b1;
    tick();
    capture_full = 1'b0; dac_empty = 1'b0;
    chk_all("both.fault", 3'd5, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk_all("both.clear", 3'd0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);

    // sw_stop while ARMED returns to IDLE
    step(); step();
    chk("armstop.armed", {29'd0, state}, 32'd2);
    sw_stop = 1'b1;
    step();
    chk("armstop.idle", {29'd0, state}, 32'd0);
    sw_stop = 1'b0;

    // adc_open drop during RUN
    arm_and_start("aclose");
    tick(); tick();
    adc_open = 1'b0;
    step();
    chk_all("aclose.idle", 3'd0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    adc_open = 1'b1;

    // Reset mid-run with frame_count = 42
    arm_and_start("rst");
    for (int i = 0; i < 42; i++) tick();
    chk("rst.cnt42", frame_count, 32'd42);
    chk("rst.cnt42.fc4", {28'd0, frame_count4}, 32'd10);
    rst = 1'b1;
    step();
    chk_all("rst.mid", 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst.mid.fc4", {28'd0, frame_count4}, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
